// File: rtl/cada_stride_agu.sv
// cada_stride_agu: strided burst address generator for one CADA bank port.
// Turns a start/count/stride command into `count` consecutive accesses at
// start, start+stride, ... wrapping modulo 2^ADDR_W.
// Optional macro CADA_AGU_PENDING_EN adds a one-entry pending command slot
// so the next burst starts on the cycle after the current burst's last access.
// Ports:
//   clk, rst (async, active-high)
//   addrIn, countIn, strideIn, writeEnIn, validIn : command input
//   accessValid, addrOut, writeEnOut, lastOut     : per-cycle access
//   doneOut : one-cycle burst-complete pulse
//   busy    : burst running (or command pending / zero-count done)
//   overflow: sticky, a command was dropped (cleared by reset only)
module cada_stride_agu #(
    parameter int ADDR_W   = 6,
    parameter int COUNT_W  = 7,
    parameter int STRIDE_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addrIn,
    input  logic [COUNT_W-1:0]  countIn,
    input  logic [STRIDE_W-1:0] strideIn,
    input  logic                writeEnIn,
    input  logic                validIn,
    output logic                accessValid,
    output logic [ADDR_W-1:0]   addrOut,
    output logic                writeEnOut,
    output logic                lastOut,
    output logic                doneOut,
    output logic                busy,
    output logic                overflow
);

    // RUN means an access is presented on the outputs this cycle.
    typedef enum logic {IDLE, RUN} state_t;

    state_t state, stateNx;

    // Active burst: address of the next access and accesses left after
    // the one currently presented.
    logic [ADDR_W-1:0]   actAddr, actAddrNx;
    logic [COUNT_W-1:0]  remain, remainNx;
    logic [STRIDE_W-1:0] actStride, actStrideNx;
    logic                actWe, actWeNx;

    logic                accessValidNx, writeEnNx, lastNx, doneNx;
    logic                busyNx, overflowNx;
    logic [ADDR_W-1:0]   addrNx;

    logic                cont, load;
    logic [ADDR_W-1:0]   ldAddr;
    logic [COUNT_W-1:0]  ldCount;
    logic [STRIDE_W-1:0] ldStride;
    logic                ldWe;

`ifdef CADA_AGU_PENDING_EN
    logic                pendValid, pendValidNx;
    logic [ADDR_W-1:0]   pendAddr, pendAddrNx;
    logic [COUNT_W-1:0]  pendCount, pendCountNx;
    logic [STRIDE_W-1:0] pendStride, pendStrideNx;
    logic                pendWe, pendWeNx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            actAddr     <= '0;
            remain      <= '0;
            actStride   <= '0;
            actWe       <= 1'b0;
            accessValid <= 1'b0;
            addrOut     <= '0;
            writeEnOut  <= 1'b0;
            lastOut     <= 1'b0;
            doneOut     <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
`ifdef CADA_AGU_PENDING_EN
            pendValid   <= 1'b0;
            pendAddr    <= '0;
            pendCount   <= '0;
            pendStride  <= '0;
            pendWe      <= 1'b0;
`endif
        end else begin
            state       <= stateNx;
            actAddr     <= actAddrNx;
            remain      <= remainNx;
            actStride   <= actStrideNx;
            actWe       <= actWeNx;
            accessValid <= accessValidNx;
            addrOut     <= addrNx;
            writeEnOut  <= writeEnNx;
            lastOut     <= lastNx;
            doneOut     <= doneNx;
            busy        <= busyNx;
            overflow    <= overflowNx;
`ifdef CADA_AGU_PENDING_EN
            pendValid   <= pendValidNx;
            pendAddr    <= pendAddrNx;
            pendCount   <= pendCountNx;
            pendStride  <= pendStrideNx;
            pendWe      <= pendWeNx;
`endif
        end
    end

    always_comb begin
        stateNx       = state;
        actAddrNx     = actAddr;
        remainNx      = remain;
        actStrideNx   = actStride;
        actWeNx       = actWe;
        accessValidNx = 1'b0;
        addrNx        = addrOut;
        writeEnNx     = writeEnOut;
        lastNx        = 1'b0;
        doneNx        = 1'b0;
        overflowNx    = overflow;
        load          = 1'b0;
        ldAddr        = addrIn;
        ldCount       = countIn;
        ldStride      = strideIn;
        ldWe          = writeEnIn;
        // More accesses of the current burst follow this cycle.
        cont          = (state == RUN) && (remain != '0);
`ifdef CADA_AGU_PENDING_EN
        pendValidNx   = pendValid;
        pendAddrNx    = pendAddr;
        pendCountNx   = pendCount;
        pendStrideNx  = pendStride;
        pendWeNx      = pendWe;
        if (!cont && pendValid) begin
            load        = 1'b1;
            ldAddr      = pendAddr;
            ldCount     = pendCount;
            ldStride    = pendStride;
            ldWe        = pendWe;
            pendValidNx = 1'b0;
            if (validIn)
                overflowNx = 1'b1;
        end else if (validIn) begin
            if (!cont) begin
                load = 1'b1;
            end else if (pendValid) begin
                overflowNx = 1'b1;
            end else begin
                pendValidNx  = 1'b1;
                pendAddrNx   = addrIn;
                pendCountNx  = countIn;
                pendStrideNx = strideIn;
                pendWeNx     = writeEnIn;
            end
        end
`else
        // Without a pending slot, even the last-access cycle refuses.
        if (validIn) begin
            if (state == RUN)
                overflowNx = 1'b1;
            else
                load = 1'b1;
        end
`endif
        if (load) begin
            if (ldCount == '0) begin
                doneNx  = 1'b1;
                stateNx = IDLE;
            end else begin
                stateNx       = RUN;
                accessValidNx = 1'b1;
                addrNx        = ldAddr;
                writeEnNx     = ldWe;
                lastNx        = (ldCount == COUNT_W'(1));
                doneNx        = (ldCount == COUNT_W'(1));
                remainNx      = ldCount - COUNT_W'(1);
                actAddrNx     = ldAddr + ADDR_W'(ldStride);
                actStrideNx   = ldStride;
                actWeNx       = ldWe;
            end
        end else if (cont) begin
            stateNx       = RUN;
            accessValidNx = 1'b1;
            addrNx        = actAddr;
            actAddrNx     = actAddr + ADDR_W'(actStride);
            remainNx      = remain - COUNT_W'(1);
            lastNx        = (remain == COUNT_W'(1));
            doneNx        = (remain == COUNT_W'(1));
        end else begin
            stateNx = IDLE;
        end
`ifdef CADA_AGU_PENDING_EN
        busyNx = accessValidNx | pendValidNx | doneNx;
`else
        busyNx = accessValidNx;
`endif
    end

endmodule

// File: tb/tb_cada_stride_agu.sv
// tb_cada_stride_agu: directed test of cada_stride_agu against a
// burst-expansion model plus hand-computed literal expectations.
module tb_cada_stride_agu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] addrIn = '0;
    logic [6:0] countIn = '0;
    logic [0:0] strideIn = '0;
    logic       writeEnIn = 1'b0;
    logic       validIn = 1'b0;
    logic       accessValid, writeEnOut, lastOut, doneOut, busy, overflow;
    logic [5:0] addrOut;

    int nCmp = 0;
    int nFail = 0;

    cada_stride_agu dut (
        .clk(clk), .rst(rst),
        .addrIn(addrIn), .countIn(countIn), .strideIn(strideIn),
        .writeEnIn(writeEnIn), .validIn(validIn),
        .accessValid(accessValid), .addrOut(addrOut),
        .writeEnOut(writeEnOut), .lastOut(lastOut), .doneOut(doneOut),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: a command expands into one record per output cycle.
    typedef struct {
        bit      av;
        int      a;
        bit      we;
        bit      last;
        bit      done;
    } cyc_t;

    typedef struct {
        int a;
        int c;
        int s;
        bit we;
    } cmd_t;

    cyc_t burst[$];
    cmd_t pendQ[$];
    bit   eAv, eWe, eLast, eDone, eBusy, eOvf;
    int   eAddr;

    function automatic void expand(cmd_t k);
        cyc_t r;
        if (k.c == 0) begin
            r = '{av: 0, a: 0, we: 0, last: 0, done: 1};
            burst.push_back(r);
        end else begin
            for (int i = 0; i < k.c; i++) begin
                r.av   = 1;
                r.a    = (k.a + i * k.s) % 64;
                r.we   = k.we;
                r.last = (i == k.c - 1);
                r.done = (i == k.c - 1);
                burst.push_back(r);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        cmd_t k;
        cyc_t r;
        bit   free;
        if (rst) begin
            burst.delete();
            pendQ.delete();
            eAv = 0; eAddr = 0; eWe = 0; eLast = 0;
            eDone = 0; eBusy = 0; eOvf = 0;
        end else begin
            k = '{a: int'(addrIn), c: int'(countIn),
                  s: int'(strideIn), we: writeEnIn};
            free = (burst.size() == 0);
`ifdef CADA_AGU_PENDING_EN
            if (free && pendQ.size() > 0) begin
                expand(pendQ.pop_front());
                if (validIn) eOvf = 1;
            end else if (validIn) begin
                if (free) expand(k);
                else if (pendQ.size() == 0) pendQ.push_back(k);
                else eOvf = 1;
            end
`else
            if (validIn) begin
                if (eAv) eOvf = 1;
                else expand(k);
            end
`endif
            if (burst.size() > 0) begin
                r = burst.pop_front();
                eAv = r.av; eLast = r.last; eDone = r.done;
                if (r.av) begin
                    eAddr = r.a;
                    eWe = r.we;
                end
            end else begin
                eAv = 0; eLast = 0; eDone = 0;
            end
`ifdef CADA_AGU_PENDING_EN
            eBusy = eAv || eDone || (pendQ.size() > 0);
`else
            eBusy = eAv;
`endif
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.accessValid", int'(accessValid), int'(eAv));
        chk("m.addrOut", int'(addrOut), eAddr);
        chk("m.writeEnOut", int'(writeEnOut), int'(eWe));
        chk("m.lastOut", int'(lastOut), int'(eLast));
        chk("m.doneOut", int'(doneOut), int'(eDone));
        chk("m.busy", int'(busy), int'(eBusy));
        chk("m.overflow", int'(overflow), int'(eOvf));
    end

    // Drive a one-cycle command; returns at the negedge of the cycle
    // in which its first access (if any) is presented.
    task automatic issue(input int a, input int c, input int s, input bit w);
        addrIn = 6'(a);
        countIn = 7'(c);
        strideIn = 1'(s);
        writeEnIn = w;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.accessValid", int'(accessValid), 0);
        chk("rst.addrOut", int'(addrOut), 0);
        chk("rst.doneOut", int'(doneOut), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.overflow", int'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write burst 0,1,2
        issue(0, 3, 1, 1);
        chk("w.av0", int'(accessValid), 1);
        chk("w.addr0", int'(addrOut), 0);
        chk("w.we0", int'(writeEnOut), 1);
        chk("w.last0", int'(lastOut), 0);
        @(negedge clk);
        chk("w.addr1", int'(addrOut), 1);
        @(negedge clk);
        chk("w.addr2", int'(addrOut), 2);
        chk("w.last2", int'(lastOut), 1);
        chk("w.done2", int'(doneOut), 1);
        @(negedge clk);
        chk("w.avAfter", int'(accessValid), 0);
        chk("w.busyAfter", int'(busy), 0);

        // Wrap read 62,63,0,1
        issue(62, 4, 1, 0);
        chk("wrap.addr0", int'(addrOut), 62);
        chk("wrap.we", int'(writeEnOut), 0);
        @(negedge clk);
        chk("wrap.addr1", int'(addrOut), 63);
        @(negedge clk);
        chk("wrap.addr2", int'(addrOut), 0);
        @(negedge clk);
        chk("wrap.addr3", int'(addrOut), 1);
        chk("wrap.last", int'(lastOut), 1);
        @(negedge clk);

        // Count 0
        issue(7, 0, 1, 1);
        chk("zero.av", int'(accessValid), 0);
        chk("zero.done", int'(doneOut), 1);
        @(negedge clk);
        chk("zero.doneOff", int'(doneOut), 0);
        chk("zero.ovf", int'(overflow), 0);

        // Stride 0 repeats the address
        issue(5, 3, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("s0.addr", int'(addrOut), 5);
            @(negedge clk);
        end

        // Zero-count command behind a running burst
        issue(0, 2, 1, 0);
        issue(9, 0, 1, 0);
        repeat (4) @(negedge clk);

        // Command arriving on the last-access cycle
        issue(20, 2, 1, 1);
        @(negedge clk);
        issue(40, 2, 1, 1);
`ifdef CADA_AGU_PENDING_EN
        chk("last.direct.av", int'(accessValid), 1);
        chk("last.direct.addr", int'(addrOut), 40);
`else
        chk("last.drop.av", int'(accessValid), 0);
        chk("last.drop.ovf", int'(overflow), 1);
`endif
        repeat (3) @(negedge clk);
        doReset();
        chk("clr.ovf", int'(overflow), 0);

        // A, B, C back to back
        issue(0, 3, 1, 1);
        issue(10, 2, 1, 0);
        issue(20, 2, 1, 0);
        chk("abc.ovf", int'(overflow), 1);
        @(negedge clk);
`ifdef CADA_AGU_PENDING_EN
        chk("abc.bAv", int'(accessValid), 1);
        chk("abc.bAddr", int'(addrOut), 10);
        @(negedge clk);
        chk("abc.bAddr1", int'(addrOut), 11);
        chk("abc.bDone", int'(doneOut), 1);
`else
        chk("abc.bDropped", int'(accessValid), 0);
        @(negedge clk);
`endif
        repeat (3) @(negedge clk);
        chk("abc.sticky", int'(overflow), 1);
        doReset();

        // Reset during second access of a count-5 burst
        issue(0, 5, 1, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid.av", int'(accessValid), 0);
        chk("mid.busy", int'(busy), 0);
        chk("mid.done", int'(doneOut), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3, 2, 1, 0);
        chk("post.av", int'(accessValid), 1);
        chk("post.addr", int'(addrOut), 3);
        @(negedge clk);
        chk("post.addr1", int'(addrOut), 4);
        chk("post.last", int'(lastOut), 1);
        @(negedge clk);
        chk("post.idle", int'(busy), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/cada_stride_agu.md
# cada_stride_agu

Strided address generator that sits directly upstream of a CADA memory bank port and turns one start/count/stride command into a burst of per-cycle memory accesses. Each command issues `count` accesses at `start`, `start+stride`, … with addresses wrapping modulo bank depth. A one-entry pending slot lets the host issue the next command while a burst is running, so bursts run back-to-back with no idle cycle. One instance serves each memory port.

## Interface
Parameters:
- `ADDR_W`, 6, bank address width (bank depth 2^ADDR_W)
- `COUNT_W`, 7, access-count width
- `STRIDE_W`, 1, stride width (unsigned)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `addrIn`  in  ADDR_W  command start address
- `countIn`  in  COUNT_W  number of accesses
- `strideIn`  in  STRIDE_W  address increment per access
- `writeEnIn`  in  1  1 = write burst, 0 = read burst
- `validIn`  in  1  command strobe, sampled every rising edge
- `accessValid`  out  1  an access is presented this cycle
- `addrOut`  out  ADDR_W  access address
- `writeEnOut`  out  1  access is a write (qualified by accessValid)
- `lastOut`  out  1  final access of the current burst
- `doneOut`  out  1  one-cycle burst-complete pulse
- `busy`  out  1  a burst is active or a command is pending
- `overflow`  out  1  sticky: a command was dropped

## Operation
- States: IDLE, RUN. Registers: active addr/remaining/stride/we; pending slot (valid, addr, count, stride, we).
- IDLE + validIn: load command into active, go RUN. If `countIn`==0: no access, `doneOut` pulses next cycle, stay IDLE.
- RUN: each cycle present one access; `addrOut` = current, then addr ← (addr + stride) mod 2^ADDR_W; remaining decrements. When remaining==1: `lastOut`=1, `doneOut`=1 same cycle.
- At end of burst: if pending valid, pending → active next cycle (no bubble), pending cleared; else → IDLE.
- validIn while RUN: if pending empty, capture into pending; if pending full, drop command, set `overflow`.
- validIn on the same cycle as the last access with pending empty: command goes directly to active, starts next cycle.
- Pending command with count 0 becomes active: one cycle with `doneOut`=1, `accessValid`=0.
- Stride 0 is legal: repeats the same address `count` times.
- `busy` = RUN or pending valid or count-0 done pending.
- `overflow` clears only on reset.

## Timing
- All outputs registered. Reset values: every output 0; state IDLE; pending empty.
- Latency: command sampled at edge N → first access valid during cycle N+1.
- Burst of count C occupies exactly C consecutive cycles; `lastOut`/`doneOut` on cycle C.
- Back-to-back: next burst's first access on the cycle immediately after previous `lastOut`.
- Reset asserted mid-burst: outputs drop to 0 asynchronously; active and pending commands discarded; no `doneOut`.
- `addrOut`/`writeEnOut` hold their last values when `accessValid`=0; consumers must qualify.

## Configuration
- `CADA_AGU_PENDING_EN` defined: one-entry pending slot present as described.
- Not defined: no pending slot; any validIn while RUN (including the last-access cycle) is dropped and sets `overflow`; next command only accepted in IDLE. `busy` = RUN only.

## Test plan
- Write burst addr 0, count 3, stride 1, validIn at edge N → accessValid cycles N+1..N+3, addrOut 0,1,2, writeEnOut=1, lastOut+doneOut on N+3, busy low after.
- Wrap: addr 62, count 4, stride 1, read → addrOut 62,63,0,1, writeEnOut=0.
- Count 0 → no accessValid; doneOut single pulse cycle N+1; overflow stays 0.
- PENDING_EN: burst A (addr 0, count 3) then B (addr 10, count 2) issued on A's 1st access → addrOut 0,1,2,10,11 contiguous, doneOut on cycles 3 and 5.
- PENDING_EN: third command while A active and B pending → dropped, overflow=1 sticky; without macro, B itself dropped and overflow=1.
- rst asserted during 2nd access of count-5 burst → accessValid, busy, doneOut 0 immediately; after release, new command runs normally from IDLE.
